// File: rtl/mandel_pkg.sv
// mandel_pkg: shared types, defaults and helpers for the Mandelbrot frame scheduler.
//   H_RES_DEFAULT / V_RES_DEFAULT : default frame geometry
//   coord_t (10b), colour_t (3b), fb_addr_t (19b)
//   sched_state_t                 : scheduler FSM states
//   fb_addr(posx, posy)           : frame-RAM address {posy[8:0], posx[9:0]}
package mandel_pkg;

   localparam int H_RES_DEFAULT = 640;
   localparam int V_RES_DEFAULT = 480;

   typedef logic [9:0]  coord_t;
   typedef logic [2:0]  colour_t;
   typedef logic [18:0] fb_addr_t;

   typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} sched_state_t;

   function automatic fb_addr_t fb_addr(input coord_t posx, input coord_t posy);
      return {posy[8:0], posx};
   endfunction

endpackage

// File: rtl/mandel_scheduler_if.sv
// mandel_scheduler_if: job, result and frame-RAM write signals between the
// scheduler (master) and the pixel engines / frame buffer (slave).
//   job_valid/job_ready/job_posx/job_posy : job offer to engines
//   res_valid/res_ready/res_posx/res_posy/res_data : result collection
//   write_address/write_data/write_enable : single frame-RAM write port
interface mandel_scheduler_if #(
   parameter int NUM_ENGINES = 4
);
   import mandel_pkg::*;

   logic [NUM_ENGINES-1:0]    job_valid;
   logic [NUM_ENGINES-1:0]    job_ready;
   coord_t                    job_posx;
   coord_t                    job_posy;
   logic [NUM_ENGINES-1:0]    res_valid;
   logic [NUM_ENGINES-1:0]    res_ready;
   logic [NUM_ENGINES*10-1:0] res_posx;
   logic [NUM_ENGINES*10-1:0] res_posy;
   logic [NUM_ENGINES*3-1:0]  res_data;
   fb_addr_t                  write_address;
   colour_t                   write_data;
   logic                      write_enable;

   modport master (
      output job_valid, job_posx, job_posy, res_ready,
             write_address, write_data, write_enable,
      input  job_ready, res_valid, res_posx, res_posy, res_data
   );

   modport slave (
      input  job_valid, job_posx, job_posy, res_ready,
             write_address, write_data, write_enable,
      output job_ready, res_valid, res_posx, res_posy, res_data
   );

endinterface

// File: rtl/mandel_rr_arbiter.sv
// mandel_rr_arbiter: round-robin arbiter with a one-hot grant.
//   iteration_clk, reset : clock, asynchronous active-high reset
//   req [N]              : request vector
//   advance              : the current grant was consumed this cycle
//   gnt [N]              : one-hot (or zero) grant, combinational from req
// After a consumed grant the search starts at the engine after the winner,
// so continuously requesting engines take turns.
module mandel_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         iteration_clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] next_ptr;
   logic [PW-1:0] idx;
   logic          found;

   always_comb begin
      gnt      = '0;
      next_ptr = ptr;
      idx      = '0;
      found    = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr) + k) % N);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            next_ptr = PW'((int'(idx) + 1) % N);
         end
      end
   end

   always_ff @(posedge iteration_clk or posedge reset) begin
      if (reset)        ptr <= '0;
      else if (advance) ptr <= next_ptr;
   end

endmodule

// File: rtl/mandel_scheduler.sv
// mandel_scheduler: frame-level controller sharing a pool of pixel engines.
// Hands out raster-order coordinates to ready engines, collects results via
// a round-robin grant and drives the single frame-RAM write port.
//   iteration_clk, reset : clock, asynchronous active-high reset
//   start                : level, starts a frame when sampled high in IDLE
//   busy                 : high from the cycle after start until frame_done ends
//   frame_done           : one-cycle pulse in DONE
//   bus (master)         : job offer, result collection and write port
//   cycles_per_frame     : busy cycles of the last frame (MANDEL_SCHED_PERF_EN only)
module mandel_scheduler
   import mandel_pkg::*;
#(
   parameter int NUM_ENGINES = 4,
   parameter int H_RES       = H_RES_DEFAULT,
   parameter int V_RES       = V_RES_DEFAULT
) (
   input  logic               iteration_clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               frame_done,
   mandel_scheduler_if.master bus
`ifdef MANDEL_SCHED_PERF_EN
   ,
   output logic [31:0]        cycles_per_frame
`endif
);

   localparam fb_addr_t FRAME_PIXELS = fb_addr_t'(H_RES * V_RES);
   localparam coord_t   X_LAST       = coord_t'(H_RES - 1);
   localparam coord_t   Y_LAST       = coord_t'(V_RES - 1);

   sched_state_t           state, state_nxt;
   coord_t                 job_x, job_y;
   fb_addr_t               issued, written;
   logic [NUM_ENGINES-1:0] job_req, job_gnt, res_req, res_gnt;
   logic                   job_xfer, res_acc, last_job;
   coord_t                 sel_x, sel_y;
   colour_t                sel_c;
   fb_addr_t               wr_addr_p1;
   colour_t                wr_data_p1;
   logic                   vld_p1;

   mandel_rr_arbiter #(.N(NUM_ENGINES)) u_job_arb (
      .iteration_clk (iteration_clk),
      .reset         (reset),
      .req           (job_req),
      .advance       (job_xfer),
      .gnt           (job_gnt)
   );

   mandel_rr_arbiter #(.N(NUM_ENGINES)) u_res_arb (
      .iteration_clk (iteration_clk),
      .reset         (reset),
      .req           (res_req),
      .advance       (res_acc),
      .gnt           (res_gnt)
   );

   assign job_xfer = |(job_gnt & bus.job_ready);
   assign res_acc  = |(res_gnt & bus.res_valid);
   assign last_job = job_xfer && (job_x == X_LAST) && (job_y == Y_LAST);

   always_ff @(posedge iteration_clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The final accept moves straight to DONE so frame_done lines up with its write.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = DISPATCH;
         DISPATCH: if (last_job) state_nxt = DRAIN;
         DRAIN:    if ((written + fb_addr_t'(res_acc)) == FRAME_PIXELS) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      job_req    = '0;
      res_req    = '0;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         DISPATCH: begin
            job_req = (issued != FRAME_PIXELS) ? bus.job_ready : '0;
            res_req = bus.res_valid;
            busy    = 1'b1;
         end
         DRAIN: begin
            res_req = bus.res_valid;
            busy    = 1'b1;
         end
         DONE: begin
            busy       = 1'b1;
            frame_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.job_valid = job_gnt;
   assign bus.res_ready = res_gnt;
   assign bus.job_posx  = job_x;
   assign bus.job_posy  = job_y;

   always_ff @(posedge iteration_clk or posedge reset) begin
      if (reset) begin
         job_x   <= '0;
         job_y   <= '0;
         issued  <= '0;
         written <= '0;
      end else if (state == IDLE && start) begin
         job_x   <= '0;
         job_y   <= '0;
         issued  <= '0;
         written <= '0;
      end else begin
         if (job_xfer) begin
            issued <= issued + 19'd1;
            if (job_x == X_LAST) begin
               job_x <= '0;
               job_y <= (job_y == Y_LAST) ? '0 : job_y + 10'd1;
            end else begin
               job_x <= job_x + 10'd1;
            end
         end
         if (res_acc) written <= written + 19'd1;
      end
   end

   always_comb begin
      sel_x = '0;
      sel_y = '0;
      sel_c = '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
         if (res_gnt[i]) begin
            sel_x = bus.res_posx[10*i +: 10];
            sel_y = bus.res_posy[10*i +: 10];
            sel_c = bus.res_data[3*i +: 3];
         end
      end
   end

   // p1: accepted result registered onto the frame-RAM write port
   always_ff @(posedge iteration_clk or posedge reset) begin
      if (reset) begin
         vld_p1     <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         vld_p1 <= res_acc;
         if (res_acc) begin
            wr_addr_p1 <= fb_addr(sel_x, sel_y);
            wr_data_p1 <= sel_c;
         end
      end
   end

   assign bus.write_enable  = vld_p1;
   assign bus.write_address = wr_addr_p1;
   assign bus.write_data    = wr_data_p1;

`ifdef MANDEL_SCHED_PERF_EN
   logic [31:0] perf_cnt;

   // The latched value includes the DONE cycle itself, i.e. every busy cycle.
   always_ff @(posedge iteration_clk or posedge reset) begin
      if (reset) begin
         perf_cnt         <= '0;
         cycles_per_frame <= '0;
      end else begin
         if (state == IDLE && start) perf_cnt <= '0;
         else if (busy)              perf_cnt <= perf_cnt + 32'd1;
         if (state == DONE) cycles_per_frame <= perf_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mandel_scheduler.sv
// tb_mandel_scheduler: scoreboard bench for mandel_scheduler (8x4 frame, 4 engines).
// Engines are modelled as per-engine job queues with configurable latency;
// every accepted result pushes its expected write into a queue popped by a
// separate write monitor. Optional MANDEL_SCHED_PERF_EN adds cycles_per_frame checks.
module tb_mandel_scheduler;

   localparam int NE    = 4;
   localparam int HR    = 8;
   localparam int VR    = 4;
   localparam int TOTAL = HR * VR;
   localparam int DEPTH = 64;

   logic iteration_clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, frame_done;
`ifdef MANDEL_SCHED_PERF_EN
   logic [31:0] cycles_per_frame;
`endif

   mandel_scheduler_if #(.NUM_ENGINES(NE)) bus ();

   mandel_scheduler #(.NUM_ENGINES(NE), .H_RES(HR), .V_RES(VR)) dut (
      .iteration_clk    (iteration_clk),
      .reset            (reset),
      .start            (start),
      .busy             (busy),
      .frame_done       (frame_done),
      .bus              (bus)
`ifdef MANDEL_SCHED_PERF_EN
      ,
      .cycles_per_frame (cycles_per_frame)
`endif
   );

   always #5 iteration_clk = ~iteration_clk;

   typedef struct {int addr; int data; int cyc;} wr_t;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // engine model storage
   int e_x[NE][DEPTH], e_y[NE][DEPTH], e_c[NE][DEPTH], e_rdy[NE][DEPTH];
   int e_head[NE], e_tail[NE];
   logic [NE-1:0] eng_mask = '1;
   int ready_pct = 100, lat_min = 1, lat_max = 4, hold_until = 0;

   // reference model state
   int m_phase = 0, m_x = 0, m_y = 0, m_issued = 0, m_written = 0;
   int jptr = 0, rptr = 0, m_frames = 0, busy_cycles = 0, frame_cyc = 0;
   wr_t exp_q[$];
   int pix_cnt[TOTAL];
   int n_writes = 0, first_wr = -1, last_wr = -1;
   int rec_n = 0, rg_n = 0;
   int rec_g[5], rec_x[5], rec_y[5], rg[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NE-1:0] req, input int ptr);
      for (int k = 0; k < NE; k++)
         if (req[(ptr + k) % NE]) return (ptr + k) % NE;
      return -1;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_issued = 0; m_written = 0; m_x = 0; m_y = 0;
      jptr = 0; rptr = 0;
      for (int i = 0; i < NE; i++) begin e_head[i] = 0; e_tail[i] = 0; end
      exp_q.delete();
   endtask

   task automatic reset_checks();
      check("rst_job_valid", bus.job_valid, 0);
      check("rst_job_posx", bus.job_posx, 0);
      check("rst_job_posy", bus.job_posy, 0);
      check("rst_res_ready", bus.res_ready, 0);
      check("rst_write_address", bus.write_address, 0);
      check("rst_write_data", bus.write_data, 0);
      check("rst_write_enable", bus.write_enable, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
   endtask

   // Engines and reference model: drive at the falling edge, evaluate 1 time unit later.
   initial begin : engines
      logic [NE-1:0] jr, rv;
      logic [NE*10-1:0] px, py;
      logic [NE*3-1:0] pc;
      int g, r, h;
      wr_t w;
      for (int i = 0; i < NE; i++) begin e_head[i] = 0; e_tail[i] = 0; end
      forever begin
         @(negedge iteration_clk);
         cyc++;
         jr = '0; rv = '0; px = '0; py = '0; pc = '0;
         if (!reset) begin
            for (int i = 0; i < NE; i++) begin
               jr[i] = eng_mask[i] && ($urandom_range(99) < ready_pct);
               h = e_head[i] % DEPTH;
               if (e_tail[i] > e_head[i] && e_rdy[i][h] <= cyc) begin
                  rv[i] = 1'b1;
                  px[10*i +: 10] = 10'(e_x[i][h]);
                  py[10*i +: 10] = 10'(e_y[i][h]);
                  pc[3*i +: 3]   = 3'(e_c[i][h]);
               end
            end
         end
         bus.job_ready = jr; bus.res_valid = rv;
         bus.res_posx = px; bus.res_posy = py; bus.res_data = pc;
         #1;
         if (reset) continue;
         check("busy", busy, m_phase != 0);
         check("frame_done", frame_done, m_phase == 2);
         if (m_phase != 0) busy_cycles++;
         // job offer
         g = (m_phase == 1 && m_issued < TOTAL) ? rr_pick(jr, jptr) : -1;
         check("job_valid", bus.job_valid, (g >= 0) ? (1 << g) : 0);
         if (g >= 0) begin
            check("job_posx", bus.job_posx, m_x);
            check("job_posy", bus.job_posy, m_y);
            if (rec_n < 5) begin
               rec_g[rec_n] = bus.job_valid; rec_x[rec_n] = bus.job_posx; rec_y[rec_n] = bus.job_posy;
               rec_n++;
            end
            h = e_tail[g] % DEPTH;
            e_x[g][h] = m_x; e_y[g][h] = m_y; e_c[g][h] = $urandom_range(7);
            e_rdy[g][h] = (hold_until > 0) ? frame_cyc + hold_until : cyc + $urandom_range(lat_max, lat_min);
            e_tail[g]++;
            m_issued++;
            if (m_x == HR - 1) begin m_x = 0; m_y++; end else m_x++;
            jptr = (g + 1) % NE;
         end
         // result collection
         r = (m_phase == 1) ? rr_pick(rv, rptr) : -1;
         check("res_ready", bus.res_ready, (r >= 0) ? (1 << r) : 0);
         if (bus.res_ready != 0 && rg_n < 8) begin rg[rg_n] = bus.res_ready; rg_n++; end
         if (r >= 0) begin
            h = e_head[r] % DEPTH;
            w.addr = e_y[r][h] * 1024 + e_x[r][h];
            w.data = e_c[r][h];
            w.cyc  = cyc;
            exp_q.push_back(w);
            e_head[r]++;
            rptr = (r + 1) % NE;
            m_written++;
         end
         // frame phase
         case (m_phase)
            0: if (start) begin
                  m_phase = 1; m_x = 0; m_y = 0; m_issued = 0; m_written = 0;
                  rec_n = 0; rg_n = 0; busy_cycles = 0; frame_cyc = cyc;
                  n_writes = 0; first_wr = -1; last_wr = -1;
                  for (int p = 0; p < TOTAL; p++) pix_cnt[p] = 0;
               end
            1: if (m_written == TOTAL) m_phase = 2;
            default: begin m_phase = 0; m_frames++; end
         endcase
      end
   end

   // Write monitor: every write must match the oldest accepted result, one cycle later.
   initial begin : monitor
      wr_t e;
      int ax, ay;
      forever begin
         @(negedge iteration_clk);
         #2;
         if (reset) continue;
         if (bus.write_enable) begin
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL write_unexpected: got address %0d expected no write (cycle %0d)", bus.write_address, cyc);
            end else begin
               e = exp_q.pop_front();
               check("write_address", bus.write_address, e.addr);
               check("write_data", bus.write_data, e.data);
               check("write_latency", cyc - e.cyc, 1);
               ax = int'(bus.write_address[9:0]);
               ay = int'(bus.write_address[18:10]);
               if (ax < HR && ay < VR) pix_cnt[ay * HR + ax]++;
               if (n_writes == 0) first_wr = int'(bus.write_address);
               last_wr = int'(bus.write_address);
               n_writes++;
            end
         end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL write_missing: got no write expected address %0d (cycle %0d)", e.addr, cyc);
         end
      end
   end

   task automatic run_frame(input bit hold_start);
      int prev, budget;
      prev = m_frames; budget = 0;
      start = 1'b1;
      @(posedge iteration_clk); #2;
      if (!hold_start) start = 1'b0;
      while (m_frames == prev && budget < 2000) begin
         @(posedge iteration_clk); #2;
         if (m_phase == 2) start = 1'b0;
         budget++;
      end
      start = 1'b0;
      check("frame_complete", m_frames != prev, 1);
   endtask

   task automatic post_frame();
      check("busy_after", busy, 0);
      check("frame_done_after", frame_done, 0);
      check("write_count", n_writes, TOTAL);
      for (int p = 0; p < TOTAL; p++) check("pixel_once", pix_cnt[p], 1);
`ifdef MANDEL_SCHED_PERF_EN
      check("cycles_per_frame", cycles_per_frame, busy_cycles);
      repeat (3) @(posedge iteration_clk);
      #2;
      check("cycles_per_frame_stable", cycles_per_frame, busy_cycles);
`endif
   endtask

   initial begin : main
      int b;
      #2;
      reset_checks();
      repeat (3) @(posedge iteration_clk);
      #2 reset = 1'b0;
      @(posedge iteration_clk); #2;

      // Frame 1: all engines always ready, start held high for the whole frame.
      eng_mask = 4'b1111; ready_pct = 100; lat_min = 1; lat_max = 4; hold_until = 0;
      run_frame(1'b1);
      post_frame();
      for (int k = 0; k < 5; k++) begin
         check("first_job_grant", rec_g[k], 1 << (k % 4));
         check("first_job_x", rec_x[k], k);
         check("first_job_y", rec_y[k], 0);
      end

      // Frame 2: one engine, fixed 3-cycle latency -> raster-order writes.
      eng_mask = 4'b0001; lat_min = 3; lat_max = 3;
      run_frame(1'b0);
      post_frame();
      check("first_write_address", first_wr, 0);
      check("last_write_address", last_wr, 3 * 1024 + 7);

      // Frame 3: engines 0 and 2 hold results until all jobs are out, then drain together.
      eng_mask = 4'b0101; hold_until = 40;
      run_frame(1'b0);
      post_frame();
      check("res_first_grant", (rg[0] == 1) || (rg[0] == 4), 1);
      for (int k = 1; k < 8; k++) check("res_alternate", rg[k], (rg[k-1] == 1) ? 4 : 1);
      hold_until = 0;

      // Frame 4: random readiness and latencies, results complete out of order.
      eng_mask = 4'b1111; ready_pct = 60; lat_min = 1; lat_max = 8;
      run_frame(1'b0);
      post_frame();

      // Frame 5: reset in the middle of dispatch, then a fresh frame.
      start = 1'b1;
      @(posedge iteration_clk); #2;
      start = 1'b0;
      b = 0;
      while (m_issued < 10 && b < 500) begin @(posedge iteration_clk); #2; b++; end
      check("mid_frame_progress", m_issued >= 10, 1);
      reset = 1'b1;
      #1;
      reset_checks();
      model_reset();
      repeat (2) @(posedge iteration_clk);
      #2 reset = 1'b0;
      @(posedge iteration_clk); #2;
      run_frame(1'b0);
      post_frame();
      check("restart_x", rec_x[0], 0);
      check("restart_y", rec_y[0], 0);

      // Frame 6: single engine with immediate results.
      eng_mask = 4'b0001; ready_pct = 100; lat_min = 1; lat_max = 1;
      run_frame(1'b0);
      post_frame();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
